// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with single-cycle basic ops and an iterative shift-add / restoring-divide unit
module alu_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  Valid_i,
   output logic                  Ready_o,
   input  logic                  Flush_i,
   input  logic [4:0]            Op_i,
   input  logic [DATA_WIDTH-1:0] SrcA_i,
   input  logic [DATA_WIDTH-1:0] SrcB_i,
   input  logic [TAG_WIDTH-1:0]  Tag_i,
   output logic                  Valid_o,
   output logic [DATA_WIDTH-1:0] Result_o,
   output logic                  Zero_o,
   output logic [TAG_WIDTH-1:0]  Tag_o
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t               r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [W-1:0]         r_m, r_hi, r_lo, r_result;
   logic [4:0]           r_op;
   logic [TAG_WIDTH-1:0] r_tag, r_tag_o;
   logic                 r_neg, r_sa, r_valid, r_zero;
   logic                 w_acc, w_mul_op, w_div_op, w_long, w_sa, w_sb, w_ge;
   logic [W-1:0]         w_mag_a, w_mag_b, w_short, w_quo, w_rem, w_long_res;
   logic [CW-1:0]        w_sh;
   logic [W:0]           w_add, w_shd, w_diff;
   logic [2*W-1:0]       w_prod, w_prod_s;

   assign Ready_o  = (r_state == IDLE) && !Flush_i;
   assign w_acc    = Valid_i && Ready_o;
   assign w_mul_op = Op_i inside {5'd11, 5'd12, 5'd13};
   assign w_div_op = Op_i inside {[5'd14:5'd17]};
   assign w_long   = w_mul_op || w_div_op;
   assign w_sa     = (Op_i inside {5'd11, 5'd12, 5'd14, 5'd16}) && SrcA_i[W-1];
   assign w_sb     = (Op_i inside {5'd11, 5'd12, 5'd14, 5'd16}) && SrcB_i[W-1];
   assign w_mag_a  = w_sa ? -SrcA_i : SrcA_i;
   assign w_mag_b  = w_sb ? -SrcB_i : SrcB_i;
   assign w_sh     = SrcB_i[CW-1:0];

   always_comb begin
      w_short = '0;
      case (Op_i)
         5'd0:    w_short = SrcA_i + SrcB_i;
         5'd1:    w_short = SrcA_i - SrcB_i;
         5'd2:    w_short = SrcA_i & SrcB_i;
         5'd3:    w_short = SrcA_i | SrcB_i;
         5'd4:    w_short = SrcB_i;
         5'd5:    w_short = {{(W-1){1'b0}}, $signed(SrcA_i) < $signed(SrcB_i)};
         5'd6:    w_short = SrcA_i << w_sh;
         5'd7:    w_short = SrcA_i ^ SrcB_i;
         5'd8:    w_short = SrcA_i >> w_sh;
         5'd9:    w_short = $signed(SrcA_i) >>> w_sh;
         5'd10:   w_short = {{(W-1){1'b0}}, SrcA_i < SrcB_i};
         default: w_short = '0;
      endcase
   end

   // Multiply: {r_hi,r_lo} holds partial product and remaining multiplier bits
   assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
   // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
   assign w_shd  = {r_hi, r_lo[W-1]};
   assign w_diff = w_shd - {1'b0, r_m};
   assign w_ge   = !w_diff[W];

   // Sign fix-up; a zero divisor forces an all-ones quotient, overflow falls out naturally
   assign w_prod     = {r_hi, r_lo};
   assign w_prod_s   = r_neg ? -w_prod : w_prod;
   assign w_quo      = (r_m == '0) ? '1 : (r_neg ? -r_lo : r_lo);
   assign w_rem      = r_sa ? -r_hi : r_hi;
   assign w_long_res = (r_op == 5'd11) ? w_prod_s[W-1:0] :
                       (r_op inside {5'd12, 5'd13}) ? w_prod_s[2*W-1:W] :
                       (r_op inside {5'd14, 5'd15}) ? w_quo : w_rem;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     w_next = !w_acc ? IDLE : w_mul_op ? MUL : w_div_op ? DIV : IDLE;
         MUL, DIV: w_next = (r_cnt == '0) ? DONE : r_state;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
      if (Flush_i) w_next = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_state <= IDLE;
      else r_state <= w_next;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_cnt    <= '0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_op     <= '0;
         r_tag    <= '0;
         r_neg    <= 1'b0;
         r_sa     <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_tag_o  <= '0;
      end else begin
         r_valid <= 1'b0;
         if (w_acc && !w_long) begin
            r_valid  <= 1'b1;
            r_result <= w_short;
            r_zero   <= (w_short == '0);
            r_tag_o  <= Tag_i;
         end else if (r_state == DONE && !Flush_i) begin
            r_valid  <= 1'b1;
            r_result <= w_long_res;
            r_zero   <= (w_long_res == '0);
            r_tag_o  <= r_tag;
         end
         if (w_acc && w_long) begin
            r_op  <= Op_i;
            r_tag <= Tag_i;
            r_cnt <= CW'(W - 1);
            r_neg <= w_sa ^ w_sb;
            r_sa  <= w_sa;
            r_m   <= w_mul_op ? w_mag_a : w_mag_b;
            r_hi  <= '0;
            r_lo  <= w_mul_op ? w_mag_b : w_mag_a;
         end else if (r_state == MUL) begin
            r_hi  <= w_add[W:1];
            r_lo  <= {w_add[0], r_lo[W-1:1]};
            r_cnt <= r_cnt - CW'(1);
         end else if (r_state == DIV) begin
            r_hi  <= w_ge ? w_diff[W-1:0] : w_shd[W-1:0];
            r_lo  <= {r_lo[W-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
         end
      end

   assign Valid_o  = r_valid;
   assign Result_o = r_result;
   assign Zero_o   = r_zero;
   assign Tag_o    = r_tag_o;
endmodule
